// File: rtl/kronos_stbuf.sv
// kronos_stbuf: in-order store buffer between the Kronos LSU and the data bus.
// Queues up to DEPTH stores, drains them one at a time to the data interface,
// and checks every load probe against the queued stores (optional forwarding).
module kronos_stbuf #(
    parameter int unsigned DEPTH             = 4,
    parameter bit          ALLOW_LOAD_BYPASS = 1'b0,
    parameter bit          CONFLICT_STALL    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rstz,
    // store enqueue
    input  logic                     st_vld,
    output logic                     st_rdy,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [3:0]               st_mask,
    // load probe
    input  logic                     ld_vld,
    input  logic [31:0]              ld_addr,
    input  logic [3:0]               ld_mask,
    output logic                     ld_hit,
    output logic [31:0]              ld_fwd_data,
    output logic                     ld_stall,
    // status
    input  logic                     bus_busy,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    // data bus
    output logic [31:0]              data_addr,
    output logic [31:0]              data_wr_data,
    output logic [3:0]               data_mask,
    output logic                     data_wr_en,
    output logic                     data_req,
    input  logic                     data_ack
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_e;

    state_e          state_q, state_d;
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_idx, rd_idx;
    logic            full, push, pop;

    logic [29:0]     ent_addr_q [DEPTH];
    logic [31:0]     ent_data_q [DEPTH];
    logic [3:0]      ent_mask_q [DEPTH];

    logic [PW:0]     ovl_cnt;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   age;
    logic            conflict;

    // Byte offsets are irrelevant: entries and probes work on word addresses.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    // Occupancy: the extra pointer MSB separates full from empty.
    assign wr_idx = wr_ptr_q[PW-1:0];
    assign rd_idx = rd_ptr_q[PW-1:0];
    assign count  = wr_ptr_q - rd_ptr_q;
    assign full   = (count == (PW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign st_rdy = ~full;
    assign push   = st_vld & ~full;
    assign pop    = data_req & data_ack;

    // Pointer next-state: one step per accepted store / acknowledged write.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end

    // Drain FSM: IDLE requests when the bus is free; ISSUE holds the request until ack.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        data_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                data_req = ~empty & ~bus_busy;
                if (data_req && !data_ack) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // An issued request is never withdrawn, whatever bus_busy does.
                data_req = 1'b1;
                if (data_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers; reset drops any in-flight request at once.
    always_ff @(posedge clk or negedge rstz) begin
        // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
        if (!rstz) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= S_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
        end
    end

    // Entry storage written at the tail on every accepted store.
    always_ff @(posedge clk) begin
        // NOTE: entry storage has no reset; validity comes only from the pointers, so stale contents are never observed.
        if (push) begin
            ent_addr_q[wr_idx] <= st_addr[31:2];
            ent_data_q[wr_idx] <= st_data;
            ent_mask_q[wr_idx] <= st_mask;
        end
    end

    // Head entry drives the bus; it stays stable until acknowledged.
    assign data_addr    = {ent_addr_q[rd_idx], 2'b00};
    assign data_wr_data = ent_data_q[rd_idx];
    assign data_mask    = ent_mask_q[rd_idx];
    assign data_wr_en   = data_req;

    // Load check: count valid entries overlapping the probe, remember the matching slot.
    always_comb begin
        ovl_cnt = '0;
        sel_idx = '0;
        age     = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            // Distance from the head decides whether slot i currently holds a queued store.
            age = PW'(i) - rd_idx;
            if (({1'b0, age} < count) &&
                (ent_addr_q[i] == ld_addr[31:2]) &&
                ((ent_mask_q[i] & ld_mask) != 4'b0)) begin
                ovl_cnt = ovl_cnt + (PW+1)'(1);
                // Forwarding requires a single overlap, so that slot is also the youngest.
                sel_idx = PW'(i);
            end
        end
    end

    assign conflict    = ld_vld && (ovl_cnt != '0);
    assign ld_hit      = ALLOW_LOAD_BYPASS && conflict && (ovl_cnt == (PW+1)'(1)) &&
                         ((ent_mask_q[sel_idx] & ld_mask) == ld_mask);
    assign ld_fwd_data = ld_hit ? ent_data_q[sel_idx] : 32'h0;
    assign ld_stall    = CONFLICT_STALL && conflict && !ld_hit;

endmodule

// File: tb/tb_kronos_stbuf.sv
// Testbench for kronos_stbuf (DEPTH=4, forwarding and conflict stall enabled):
// directed vector table, a mid-transaction reset sequence, and a randomized
// run against a queue-based reference model.
module tb_kronos_stbuf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstz;
    logic        st_vld, st_rdy;
    logic [31:0] st_addr, st_data;
    logic [3:0]  st_mask;
    logic        ld_vld;
    logic [31:0] ld_addr;
    logic [3:0]  ld_mask;
    logic        ld_hit, ld_stall;
    logic [31:0] ld_fwd_data;
    logic        bus_busy, empty;
    logic [2:0]  count;
    logic [31:0] data_addr, data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en, data_req, data_ack;

    kronos_stbuf #(
        .DEPTH            (DEPTH),
        .ALLOW_LOAD_BYPASS(1'b1),
        .CONFLICT_STALL   (1'b1)
    ) dut (
        .clk         (clk),
        .rstz        (rstz),
        .st_vld      (st_vld),
        .st_rdy      (st_rdy),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_mask     (st_mask),
        .ld_vld      (ld_vld),
        .ld_addr     (ld_addr),
        .ld_mask     (ld_mask),
        .ld_hit      (ld_hit),
        .ld_fwd_data (ld_fwd_data),
        .ld_stall    (ld_stall),
        .bus_busy    (bus_busy),
        .empty       (empty),
        .count       (count),
        .data_addr   (data_addr),
        .data_wr_data(data_wr_data),
        .data_mask   (data_mask),
        .data_wr_en  (data_wr_en),
        .data_req    (data_req),
        .data_ack    (data_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One directed cycle: inputs applied, then the expected pre-edge outputs.
    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [3:0]  sm;
        logic        lv;
        logic [31:0] la;
        logic [3:0]  lm;
        logic        busy;
        logic        ack;
        logic        e_rdy;
        int          e_count;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_hit;
        logic [31:0] e_fwd;
        logic        e_stall;
    } vec_t;

    function automatic vec_t v(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic [3:0] sm, input logic lv, input logic [31:0] la,
                               input logic [3:0] lm, input logic busy, input logic ack,
                               input logic e_rdy, input int e_count, input logic e_req,
                               input logic [31:0] e_addr, input logic e_hit,
                               input logic [31:0] e_fwd, input logic e_stall);
        vec_t r;
        r.sv = sv;  r.sa = sa;  r.sd = sd;  r.sm = sm;
        r.lv = lv;  r.la = la;  r.lm = lm;
        r.busy = busy;  r.ack = ack;
        r.e_rdy = e_rdy;  r.e_count = e_count;  r.e_req = e_req;  r.e_addr = e_addr;
        r.e_hit = e_hit;  r.e_fwd = e_fwd;  r.e_stall = e_stall;
        return r;
    endfunction

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [3:0] sm, input logic lv, input logic [31:0] la,
                         input logic [3:0] lm, input logic busy, input logic ack);
        st_vld = sv;  st_addr = sa;  st_data = sd;  st_mask = sm;
        ld_vld = lv;  ld_addr = la;  ld_mask = lm;
        bus_busy = busy;  data_ack = ack;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered queue of stores plus an "issued" flag.
    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  m;
    } ent_t;

    ent_t        mq[$];
    bit          m_issued;
    vec_t        vecs[22];

    int          cnt, n_ovl, sel;
    logic        e_rdy, e_req, e_hit, e_stall;
    logic [31:0] e_fwd;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            st: vld addr       data          mask  ld: vld addr       mask  busy ack | rdy cnt req addr       hit fwd           stall
        vecs[0]  = v(1, 32'h100, 32'h1111_1111, 4'hF, 0, 32'h0,   4'h0, 0, 0,  1, 0, 0, 32'h0,   0, 32'h0,         0);
        vecs[1]  = v(1, 32'h104, 32'h2222_2222, 4'hF, 0, 32'h0,   4'h0, 0, 0,  1, 1, 1, 32'h100, 0, 32'h0,         0);
        vecs[2]  = v(1, 32'h108, 32'h3333_3333, 4'hF, 0, 32'h0,   4'h0, 0, 0,  1, 2, 1, 32'h100, 0, 32'h0,         0);
        vecs[3]  = v(1, 32'h10C, 32'h4444_4444, 4'hF, 0, 32'h0,   4'h0, 0, 0,  1, 3, 1, 32'h100, 0, 32'h0,         0);
        vecs[4]  = v(1, 32'h110, 32'h5555_5555, 4'hF, 1, 32'h104, 4'h3, 0, 0,  0, 4, 1, 32'h100, 1, 32'h2222_2222, 0);
        vecs[5]  = v(1, 32'h110, 32'h5555_5555, 4'hF, 0, 32'h0,   4'h0, 0, 1,  0, 4, 1, 32'h100, 0, 32'h0,         0);
        vecs[6]  = v(1, 32'h110, 32'h5555_5555, 4'hF, 0, 32'h0,   4'h0, 0, 0,  1, 3, 1, 32'h104, 0, 32'h0,         0);
        vecs[7]  = v(0, 32'h0,   32'h0,         4'h0, 0, 32'h0,   4'h0, 0, 1,  0, 4, 1, 32'h104, 0, 32'h0,         0);
        vecs[8]  = v(0, 32'h0,   32'h0,         4'h0, 0, 32'h0,   4'h0, 0, 1,  1, 3, 1, 32'h108, 0, 32'h0,         0);
        vecs[9]  = v(0, 32'h0,   32'h0,         4'h0, 0, 32'h0,   4'h0, 0, 1,  1, 2, 1, 32'h10C, 0, 32'h0,         0);
        vecs[10] = v(0, 32'h0,   32'h0,         4'h0, 0, 32'h0,   4'h0, 0, 1,  1, 1, 1, 32'h110, 0, 32'h0,         0);
        vecs[11] = v(0, 32'h0,   32'h0,         4'h0, 0, 32'h0,   4'h0, 0, 0,  1, 0, 0, 32'h0,   0, 32'h0,         0);
        vecs[12] = v(1, 32'h200, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,   4'h0, 0, 0,  1, 0, 0, 32'h0,   0, 32'h0,         0);
        vecs[13] = v(0, 32'h0,   32'h0,         4'h0, 1, 32'h200, 4'h3, 1, 0,  1, 1, 0, 32'h0,   1, 32'hDEAD_BEEF, 0);
        vecs[14] = v(1, 32'h300, 32'h0000_00AA, 4'h1, 1, 32'h300, 4'h3, 1, 0,  1, 1, 0, 32'h0,   0, 32'h0,         0);
        vecs[15] = v(0, 32'h0,   32'h0,         4'h0, 1, 32'h300, 4'h3, 1, 0,  1, 2, 0, 32'h0,   0, 32'h0,         1);
        vecs[16] = v(0, 32'h0,   32'h0,         4'h0, 1, 32'h304, 4'h3, 1, 0,  1, 2, 0, 32'h0,   0, 32'h0,         0);
        vecs[17] = v(0, 32'h0,   32'h0,         4'h0, 1, 32'h300, 4'h1, 0, 0,  1, 2, 1, 32'h200, 1, 32'h0000_00AA, 0);
        vecs[18] = v(1, 32'h300, 32'h0000_00BB, 4'h1, 0, 32'h0,   4'h0, 1, 0,  1, 2, 1, 32'h200, 0, 32'h0,         0);
        vecs[19] = v(0, 32'h0,   32'h0,         4'h0, 1, 32'h300, 4'h1, 1, 0,  1, 3, 1, 32'h200, 0, 32'h0,         1);
        vecs[20] = v(0, 32'h0,   32'h0,         4'h0, 1, 32'h200, 4'hF, 1, 1,  1, 3, 1, 32'h200, 1, 32'hDEAD_BEEF, 0);
        vecs[21] = v(0, 32'h0,   32'h0,         4'h0, 0, 32'h0,   4'h0, 1, 0,  1, 2, 0, 32'h0,   0, 32'h0,         0);

        // Reset state.
        rstz = 1'b0;
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 0);
        #12;
        check("reset data_req", data_req, 1'b0);
        check("reset empty",    empty,    1'b1);
        check("reset count",    count,    0);
        check("reset st_rdy",   st_rdy,   1'b1);
        check("reset ld_hit",   ld_hit,   1'b0);
        check("reset ld_stall", ld_stall, 1'b0);
        @(posedge clk);
        #1 rstz = 1'b1;

        // Directed vector table: fill, full-with-pop, drain, load checks, bus_busy.
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].sm, vecs[i].lv, vecs[i].la,
                  vecs[i].lm, vecs[i].busy, vecs[i].ack);
            #2;
            check($sformatf("vec%0d st_rdy", i),   st_rdy,   vecs[i].e_rdy);
            check($sformatf("vec%0d count", i),    count,    vecs[i].e_count);
            check($sformatf("vec%0d empty", i),    empty,    vecs[i].e_count == 0);
            check($sformatf("vec%0d data_req", i), data_req, vecs[i].e_req);
            if (vecs[i].e_req)
                check($sformatf("vec%0d data_addr", i), data_addr, vecs[i].e_addr);
            check($sformatf("vec%0d ld_hit", i),   ld_hit,      vecs[i].e_hit);
            check($sformatf("vec%0d ld_fwd", i),   ld_fwd_data, vecs[i].e_fwd);
            check($sformatf("vec%0d ld_stall", i), ld_stall,    vecs[i].e_stall);
            next_cycle();
        end

        // Reset while a request is in ISSUE with three entries queued.
        drive(1, 32'h400, 32'h1234_5678, 4'hF, 0, 32'h0, 4'h0, 1, 0);
        #2;
        check("rst_seq pre count", count, 2);
        next_cycle();
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 0);
        #2;
        check("rst_seq issue req", data_req, 1'b1);
        check("rst_seq count3",    count,    3);
        next_cycle();
        #1;
        check("rst_seq held req", data_req, 1'b1);
        #1 rstz = 1'b0;
        #1;
        check("rst_seq async req",   data_req, 1'b0);
        check("rst_seq async empty", empty,    1'b1);
        check("rst_seq async count", count,    0);
        next_cycle();
        rstz = 1'b1;
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            #2;
            check($sformatf("rst_seq stale req%0d", i), data_req, 1'b0);
            check($sformatf("rst_seq stale cnt%0d", i), count,    0);
            next_cycle();
        end

        // Randomized run against the queue model (buffer starts empty and idle).
        mq.delete();
        m_issued = 1'b0;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)),
                  32'h400 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3)),
                  $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  32'h400 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3)),
                  4'($urandom_range(1, 15)),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)));
            #2;
            cnt   = mq.size();
            e_rdy = (cnt < DEPTH);
            e_req = m_issued || (cnt != 0 && !bus_busy);
            n_ovl = 0;
            sel   = 0;
            for (int k = 0; k < cnt; k++) begin
                if (mq[k].w == ld_addr[31:2] && (mq[k].m & ld_mask) != 4'h0) begin
                    n_ovl++;
                    sel = k;
                end
            end
            e_hit   = ld_vld && n_ovl == 1 && ((mq[sel].m & ld_mask) == ld_mask);
            e_fwd   = e_hit ? mq[sel].d : 32'h0;
            e_stall = ld_vld && n_ovl > 0 && !e_hit;

            check("rnd st_rdy",     st_rdy,      e_rdy);
            check("rnd count",      count,       cnt);
            check("rnd empty",      empty,       cnt == 0);
            check("rnd data_req",   data_req,    e_req);
            check("rnd data_wr_en", data_wr_en,  e_req);
            if (e_req) begin
                check("rnd data_addr", data_addr,    {mq[0].w, 2'b00});
                check("rnd data_wdat", data_wr_data, mq[0].d);
                check("rnd data_mask", data_mask,    mq[0].m);
            end
            check("rnd ld_hit",   ld_hit,      e_hit);
            check("rnd ld_fwd",   ld_fwd_data, e_fwd);
            check("rnd ld_stall", ld_stall,    e_stall);

            @(posedge clk);
            if (e_req && data_ack) begin
                void'(mq.pop_front());
                m_issued = 1'b0;
            end else if (e_req) begin
                m_issued = 1'b1;
            end
            if (st_vld && e_rdy)
                mq.push_back('{w: st_addr[31:2], d: st_data, m: st_mask});
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
